// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's hazard controls, redirect, instruction-memory
// port and decode-stage outputs. master = fetch stage, slave = its environment.
interface fetch_stage_if;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic [6:0]  OpD;
    logic [2:0]  funct3D;
    logic [6:0]  funct7D;

    modport master (
        input  StallF, StallD, FlushD, PCSrcE, PCTargetE,
        input  imem_rdata, imem_valid,
        output imem_addr,
        output InstrD, PCD, PCPlus4D, ValidD, OpD, funct3D, funct7D
    );

    modport slave (
        output StallF, StallD, FlushD, PCSrcE, PCTargetE,
        output imem_rdata, imem_valid,
        input  imem_addr,
        input  InstrD, PCD, PCPlus4D, ValidD, OpD, funct3D, funct7D
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/MISS control FSM and the
// IF/ID pipeline register with stall, flush and redirect handling.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        MISS = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] instrd_q, instrd_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcplus4d_q, pcplus4d_d;
    logic        validd_q, validd_d;

    logic        in_boot;
    logic        word_ok;
    logic [31:0] pcplus4f;
    logic [31:0] target_aligned;

    assign pcplus4f       = pcf_q + 32'd4;
    assign target_aligned = bus.PCTargetE & ~32'h0000_0003;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (!bus.imem_valid && !bus.PCSrcE) begin
                    state_d = MISS;
                end
            end
            MISS: begin
                if (bus.imem_valid || bus.PCSrcE) begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // The BOOT cycle never accepts a word, even if memory claims it is valid.
    always_comb begin
        in_boot = 1'b0;
        word_ok = 1'b0;
        case (state_q)
            BOOT:    in_boot = 1'b1;
            RUN,
            MISS:    word_ok = bus.imem_valid;
            default: in_boot = 1'b1;
        endcase
    end

    // ---------------- PC next value ----------------
    always_comb begin
        pcf_d = pcf_q;
        if (bus.PCSrcE) begin
            pcf_d = target_aligned;
        end else if (bus.StallF) begin
            pcf_d = pcf_q;
        end else if (word_ok) begin
            pcf_d = pcplus4f;
        end
    end

    // ---------------- IF/ID next value ----------------
    // A redirect discards the word currently in flight, so it bubbles D too.
    always_comb begin
        instrd_d   = instrd_q;
        pcd_d      = pcd_q;
        pcplus4d_d = pcplus4d_q;
        validd_d   = validd_q;
        if (bus.FlushD) begin
            instrd_d   = NOP_INSTR;
            pcd_d      = 32'h0;
            pcplus4d_d = 32'h0;
            validd_d   = 1'b0;
        end else if (bus.StallD) begin
            instrd_d   = instrd_q;
        end else if (in_boot || !word_ok || bus.PCSrcE) begin
            instrd_d   = NOP_INSTR;
            pcd_d      = 32'h0;
            pcplus4d_d = 32'h0;
            validd_d   = 1'b0;
        end else begin
            instrd_d   = bus.imem_rdata;
            pcd_d      = pcf_q;
            pcplus4d_d = pcplus4f;
            validd_d   = 1'b1;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcf_q      <= RESET_PC;
            instrd_q   <= NOP_INSTR;
            pcd_q      <= 32'h0;
            pcplus4d_q <= 32'h0;
            validd_q   <= 1'b0;
        end else begin
            pcf_q      <= pcf_d;
            instrd_q   <= instrd_d;
            pcd_q      <= pcd_d;
            pcplus4d_q <= pcplus4d_d;
            validd_q   <= validd_d;
        end
    end

    assign bus.imem_addr = pcf_q;
    assign bus.InstrD    = instrd_q;
    assign bus.PCD       = pcd_q;
    assign bus.PCPlus4D  = pcplus4d_q;
    assign bus.ValidD    = validd_q;
    assign bus.OpD       = instrd_q[6:0];
    assign bus.funct3D   = instrd_q[14:12];
    assign bus.funct7D   = instrd_q[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table for the main pipeline flow
// plus hand-written sequences for async reset and PC wrap-around.
module tb_fetch_stage;

    logic clk;
    logic rst;

    fetch_stage_if bus ();
    fetch_stage_if wbus ();

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (wbus.master)
    );

    // Memory model: word at index i holds 0x00100093 + i.
    assign bus.imem_rdata  = 32'h0010_0093 + (bus.imem_addr >> 2);
    assign wbus.imem_rdata = 32'h0010_0093 + (wbus.imem_addr >> 2);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks;
    int failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sf, sd, fd, src;
        logic [31:0] tgt;
        logic        vld;
        logic [31:0] pcf, instr, pcd, p4;
        logic        vd;
    } vec_t;

    function automatic vec_t v(input logic sf, input logic sd, input logic fd,
                               input logic src, input logic [31:0] tgt, input logic vld,
                               input logic [31:0] pcf, input logic [31:0] instr,
                               input logic [31:0] pcd, input logic [31:0] p4,
                               input logic vd);
        vec_t r;
        r.sf = sf; r.sd = sd; r.fd = fd; r.src = src; r.tgt = tgt; r.vld = vld;
        r.pcf = pcf; r.instr = instr; r.pcd = pcd; r.p4 = p4; r.vd = vd;
        return r;
    endfunction

    localparam logic [31:0] NOP = 32'h0000_0013;

    task automatic chk_dut(input string tag, input logic [31:0] pcf, input logic [31:0] instr,
                           input logic [31:0] pcd, input logic [31:0] p4, input logic vd);
        logic [31:0] e;
        e = instr;
        chk({tag, ".PCF"},      bus.imem_addr, pcf);
        chk({tag, ".InstrD"},   bus.InstrD, instr);
        chk({tag, ".PCD"},      bus.PCD, pcd);
        chk({tag, ".PCPlus4D"}, bus.PCPlus4D, p4);
        chk({tag, ".ValidD"},   {31'b0, bus.ValidD}, {31'b0, vd});
        chk({tag, ".OpD"},      {25'b0, bus.OpD}, {25'b0, e[6:0]});
        chk({tag, ".funct3D"},  {29'b0, bus.funct3D}, {29'b0, e[14:12]});
        chk({tag, ".funct7D"},  {25'b0, bus.funct7D}, {25'b0, e[31:25]});
    endtask

    task automatic chk_wrap(input string tag, input logic [31:0] pcf, input logic [31:0] instr,
                            input logic [31:0] pcd, input logic [31:0] p4, input logic vd);
        chk({tag, ".PCF"},      wbus.imem_addr, pcf);
        chk({tag, ".InstrD"},   wbus.InstrD, instr);
        chk({tag, ".PCD"},      wbus.PCD, pcd);
        chk({tag, ".PCPlus4D"}, wbus.PCPlus4D, p4);
        chk({tag, ".ValidD"},   {31'b0, wbus.ValidD}, {31'b0, vd});
    endtask

    vec_t tbl[28];

    initial begin
        checks   = 0;
        failures = 0;

        //          sf   sd   fd   src  tgt            vld   PCF           InstrD        PCD           PCPlus4D      ValidD
        tbl[0]  = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h0000_0000,NOP,          32'h0,        32'h0,        1'b0); // BOOT
        tbl[1]  = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h0000_0004,32'h0010_0093,32'h0000_0000,32'h0000_0004,1'b1);
        tbl[2]  = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h0000_0008,32'h0010_0094,32'h0000_0004,32'h0000_0008,1'b1);
        tbl[3]  = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h0000_000C,32'h0010_0095,32'h0000_0008,32'h0000_000C,1'b1);
        tbl[4]  = v(1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1, 32'h0000_000C,32'h0010_0095,32'h0000_0008,32'h0000_000C,1'b1); // stall x3
        tbl[5]  = v(1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1, 32'h0000_000C,32'h0010_0095,32'h0000_0008,32'h0000_000C,1'b1);
        tbl[6]  = v(1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1, 32'h0000_000C,32'h0010_0095,32'h0000_0008,32'h0000_000C,1'b1);
        tbl[7]  = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h0000_0010,32'h0010_0096,32'h0000_000C,32'h0000_0010,1'b1);
        tbl[8]  = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h0000_0014,32'h0010_0097,32'h0000_0010,32'h0000_0014,1'b1);
        tbl[9]  = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h0000_0018,32'h0010_0098,32'h0000_0014,32'h0000_0018,1'b1);
        tbl[10] = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h0000_001C,32'h0010_0099,32'h0000_0018,32'h0000_001C,1'b1);
        tbl[11] = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h0000_0020,32'h0010_009A,32'h0000_001C,32'h0000_0020,1'b1);
        tbl[12] = v(1'b0,1'b0,1'b0,1'b1,32'h0000_0102,1'b1, 32'h0000_0100,NOP,          32'h0,        32'h0,        1'b0); // redirect
        tbl[13] = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h0000_0104,32'h0010_00D3,32'h0000_0100,32'h0000_0104,1'b1);
        tbl[14] = v(1'b0,1'b0,1'b0,1'b1,32'h0000_0041,1'b1, 32'h0000_0040,NOP,          32'h0,        32'h0,        1'b0);
        tbl[15] = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0, 32'h0000_0040,NOP,          32'h0,        32'h0,        1'b0); // miss x2
        tbl[16] = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0, 32'h0000_0040,NOP,          32'h0,        32'h0,        1'b0);
        tbl[17] = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h0000_0044,32'h0010_00A3,32'h0000_0040,32'h0000_0044,1'b1);
        tbl[18] = v(1'b1,1'b0,1'b1,1'b0,32'h0,        1'b1, 32'h0000_0044,NOP,          32'h0,        32'h0,        1'b0); // flush+stallF
        tbl[19] = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h0000_0048,32'h0010_00A4,32'h0000_0044,32'h0000_0048,1'b1);
        tbl[20] = v(1'b1,1'b1,1'b1,1'b0,32'h0,        1'b1, 32'h0000_0048,NOP,          32'h0,        32'h0,        1'b0); // flush beats stallD
        tbl[21] = v(1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1, 32'h0000_0048,NOP,          32'h0,        32'h0,        1'b0);
        tbl[22] = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h0000_004C,32'h0010_00A5,32'h0000_0048,32'h0000_004C,1'b1);
        tbl[23] = v(1'b1,1'b0,1'b0,1'b1,32'h0000_0203,1'b1, 32'h0000_0200,NOP,          32'h0,        32'h0,        1'b0); // redirect beats stallF
        tbl[24] = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h0000_0204,32'h0010_0113,32'h0000_0200,32'h0000_0204,1'b1);
        tbl[25] = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0, 32'h0000_0204,NOP,          32'h0,        32'h0,        1'b0);
        tbl[26] = v(1'b0,1'b0,1'b0,1'b1,32'h0000_0010,1'b0, 32'h0000_0010,NOP,          32'h0,        32'h0,        1'b0); // redirect in MISS
        tbl[27] = v(1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1, 32'h0000_0014,32'h0010_0097,32'h0000_0010,32'h0000_0014,1'b1);

        rst = 1'b0;
        bus.StallF = 1'b0;  bus.StallD = 1'b0;  bus.FlushD = 1'b0;
        bus.PCSrcE = 1'b0;  bus.PCTargetE = 32'h0;  bus.imem_valid = 1'b1;
        wbus.StallF = 1'b0; wbus.StallD = 1'b0; wbus.FlushD = 1'b0;
        wbus.PCSrcE = 1'b0; wbus.PCTargetE = 32'h0; wbus.imem_valid = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk_dut("reset", 32'h0, NOP, 32'h0, 32'h0, 1'b0);
        chk_wrap("reset_wrap", 32'hFFFF_FFFC, NOP, 32'h0, 32'h0, 1'b0);
        $display("reset: PCF=0x%08h InstrD=0x%08h ValidD=%0b", bus.imem_addr, bus.InstrD, bus.ValidD);

        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 28; i++) begin
            bus.StallF     = tbl[i].sf;
            bus.StallD     = tbl[i].sd;
            bus.FlushD     = tbl[i].fd;
            bus.PCSrcE     = tbl[i].src;
            bus.PCTargetE  = tbl[i].tgt;
            bus.imem_valid = tbl[i].vld;
            @(posedge clk);
            #1;
            chk_dut($sformatf("vec%0d", i), tbl[i].pcf, tbl[i].instr, tbl[i].pcd, tbl[i].p4, tbl[i].vd);
            $display("vec %0d: PCF=0x%08h InstrD=0x%08h PCD=0x%08h PCPlus4D=0x%08h ValidD=%0b",
                     i, bus.imem_addr, bus.InstrD, bus.PCD, bus.PCPlus4D, bus.ValidD);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a redirect request.
        bus.StallF = 1'b0; bus.StallD = 1'b0; bus.FlushD = 1'b0; bus.imem_valid = 1'b1;
        bus.PCSrcE = 1'b1; bus.PCTargetE = 32'h0000_0300;
        #2;
        rst = 1'b0;
        #1;
        chk_dut("async_rst", 32'h0, NOP, 32'h0, 32'h0, 1'b0);
        chk_wrap("async_rst_wrap", 32'hFFFF_FFFC, NOP, 32'h0, 32'h0, 1'b0);
        $display("async reset: PCF=0x%08h ValidD=%0b", bus.imem_addr, bus.ValidD);
        bus.PCSrcE = 1'b0;
        @(posedge clk);
        #1;
        chk_dut("rst_held", 32'h0, NOP, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        @(posedge clk);
        #1;
        chk_dut("boot2", 32'h0, NOP, 32'h0, 32'h0, 1'b0);
        chk_wrap("wrap_boot", 32'hFFFF_FFFC, NOP, 32'h0, 32'h0, 1'b0);
        $display("post-reset edge1: PCF=0x%08h wrap PCF=0x%08h", bus.imem_addr, wbus.imem_addr);

        @(posedge clk);
        #1;
        chk_dut("first_fetch", 32'h0000_0004, 32'h0010_0093, 32'h0, 32'h0000_0004, 1'b1);
        chk_wrap("wrap_first", 32'h0000_0000, 32'h4010_0092, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1);
        $display("post-reset edge2: PCD=0x%08h wrap PCD=0x%08h wrap PCPlus4D=0x%08h",
                 bus.PCD, wbus.PCD, wbus.PCPlus4D);

        @(posedge clk);
        #1;
        chk_wrap("wrap_second", 32'h0000_0004, 32'h0010_0093, 32'h0000_0000, 32'h0000_0004, 1'b1);
        $display("post-reset edge3: wrap PCF=0x%08h wrap PCD=0x%08h", wbus.imem_addr, wbus.PCD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, meaning bubble instruction (addi x0,x0,0).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 StallF  input  1  hold PC this cycle.
REQ-006 StallD  input  1  hold IF/ID register this cycle.
REQ-007 FlushD  input  1  load bubble into IF/ID register this cycle.
REQ-008 PCSrcE  input  1  redirect request (taken branch/jump from execute).
REQ-009 PCTargetE  input  32  redirect address.
REQ-010 imem_addr  output  32  instruction memory address, equals PCF.
REQ-011 imem_rdata  input  32  instruction word for imem_addr, same-cycle (combinational read).
REQ-012 imem_valid  input  1  imem_rdata valid this cycle.
REQ-013 InstrD  output  32  decode-stage instruction.
REQ-014 PCD  output  32  address of InstrD.
REQ-015 PCPlus4D  output  32  PCD + 4.
REQ-016 ValidD  output  1  InstrD is a real instruction (0 = bubble).
REQ-017 OpD / funct3D / funct7D  output  7/3/7  InstrD[6:0] / InstrD[14:12] / InstrD[31:25], feeding the decode-stage control unit.

Function
REQ-018 PCF register; imem_addr = PCF at all times; PCPlus4F = PCF + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-019 FSM states: BOOT (first cycle after reset release, no fetch accepted), RUN (fetching), MISS (previous cycle imem_valid = 0); BOOT->RUN unconditionally; RUN->MISS when imem_valid = 0 and no redirect; MISS->RUN when imem_valid = 1 or PCSrcE = 1.
REQ-020 PC next-value priority: PCSrcE=1 -> {PCTargetE[31:2],2'b00}; else StallF=1 -> hold; else BOOT or imem_valid=0 -> hold; else PCPlus4F.
REQ-021 PCSrcE overrides StallF; redirect target low two bits forced to zero.
REQ-022 IF/ID priority: FlushD=1 -> InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0; else StallD=1 -> hold all; else BOOT or imem_valid=0 or PCSrcE=1 -> bubble (as flush); else capture imem_rdata, PCF, PCPlus4F, ValidD=1.
REQ-023 FlushD overrides StallD; simultaneous FlushD and StallF: PC holds, D gets bubble.
REQ-024 Latency: instruction fetched at PCF with imem_valid=1 in cycle n appears on InstrD in cycle n+1; steady-state throughput one instruction per cycle.
REQ-025 Redirect penalty: PCSrcE in cycle n -> PCF = target in cycle n+1, target instruction on InstrD no earlier than cycle n+2; word in flight at cycle n is discarded.
REQ-026 OpD/funct3D/funct7D are pure wiring of InstrD; bubble yields OpD=7'b0010011, funct3D=0, funct7D=0.
REQ-027 No instruction is lost or duplicated across any mix of stall, miss and redirect; each PC with ValidD=1 appears exactly once per pass.

Reset
REQ-028 rst=0 asynchronously forces PCF=RESET_PC, state=BOOT, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, regardless of clk.
REQ-029 Reset asserted mid-stall, mid-miss or mid-redirect discards all in-flight state; first fetch after release is RESET_PC.
REQ-030 Deassertion takes effect on the first rising clk edge with rst=1; that cycle is BOOT.

Verification
REQ-031 Reset release, imem_valid=1, memory word[i]=0x00100093+i -> PCF 0,0,4,8...; InstrD at cycle 2 = 0x00100093, PCD=0, PCPlus4D=4, ValidD=1.
REQ-032 StallF=StallD=1 for 3 cycles at PCD=8 -> InstrD/PCD frozen, PCF frozen at 0xC; release resumes with PCD=0xC next cycle, no skip.
REQ-033 PCSrcE=1, PCTargetE=0x0000_0102 at PCF=0x20 -> next PCF=0x100, next ValidD=0, InstrD=0x00000013; following cycle PCD=0x100.
REQ-034 imem_valid=0 for 2 cycles at PCF=0x40 -> PCF holds 0x40, two bubbles (ValidD=0); first valid cycle then PCD=0x40 next edge.
REQ-035 RESET_PC=0xFFFF_FFFC -> second fetch PCF=0x0000_0000, PCPlus4D of first instruction = 0x0000_0000.
REQ-036 rst pulsed low mid-redirect (asynchronously, between edges) -> outputs at reset values immediately, PCF=RESET_PC, no pending redirect taken after release.
